// File: rtl/core_pkg.sv
// Shared fetch-path types: control state encoding, buffered instruction entry,
// and small address helpers used by the fetch unit and its instruction buffer.
package core_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of {inst, pc} entries with a combinational head,
// simultaneous push/pop (also when full) and a single-cycle flush.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_flush,
   input  logic                           i_push,
   input  fetch_entry_t                   i_push_entry,
   input  logic                           i_pop,
   output fetch_entry_t                   o_head,
   output logic [$clog2(FIFO_DEPTH):0]    o_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

   fetch_entry_t mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = i_pop && (count_q != '0) && !i_flush;
      // A push into a full buffer is only legal when the head leaves in the same cycle.
      do_push  = i_push && ((count_q != DEPTH_C) || do_pop) && !i_flush;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_push_entry;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses, and drops
// stale responses after a redirect. Optional stall counter under FETCH_STALL_CNT_EN.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] o_stall_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;

   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   in_flight;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;
   logic             ack_fire;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;

   // Requests in flight plus buffered entries may never exceed the buffer, so every
   // response always has a slot waiting for it.
   assign in_flight   = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign o_imem_req  = !i_reset && (state_q == FETCH) && (in_flight < DEPTH_W);
   assign o_imem_addr = pc_q;
   assign ack_fire    = o_imem_req && i_imem_ack;

   assign o_inst_valid = (fifo_count != '0);
   assign o_inst       = fifo_head.inst;
   assign o_inst_pc    = fifo_head.pc;
   assign fifo_pop     = o_inst_valid && i_inst_ready;
   assign push_entry   = '{inst: i_imem_rdata, pc: resp_pc_q};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      fifo_push     = 1'b0;
      fifo_flush    = 1'b0;
      outstanding_d = outstanding_q + CNT_W'(ack_fire) - CNT_W'(i_imem_rvalid);

      if (i_redirect) begin
         // Everything still owed by memory after this edge belongs to the old stream,
         // including a request accepted in this very cycle.
         fifo_flush = 1'b1;
         pc_d       = align_word(i_redirect_pc);
         resp_pc_d  = align_word(i_redirect_pc);
         discard_d  = outstanding_d;
         state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (ack_fire) begin
                  pc_d = pc_q + PC_STEP;
               end
               if (i_imem_rvalid) begin
                  fifo_push = 1'b1;
                  resp_pc_d = resp_pc_q + PC_STEP;
               end
            end
            DRAIN: begin
               if (i_imem_rvalid) begin
                  discard_d = discard_q - CNT_W'(1);
                  if (discard_q == CNT_W'(1)) begin
                     state_d = FETCH;
                  end
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_flush      (fifo_flush),
      .i_push       (fifo_push),
      .i_push_entry (push_entry),
      .i_pop        (fifo_pop),
      .o_head       (fifo_head),
      .o_count      (fifo_count)
   );

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Counts cycles where decode wanted an instruction but the buffer was empty.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (i_inst_ready && !o_inst_valid) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters) with a simple
// in-order memory responder; stall counter test runs when FETCH_STALL_CNT_EN is defined.
module tb_fetch_unit;

   localparam logic [31:0] INST_KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   logic        ack_en;
   logic        resp_en;
   logic [31:0] pend_addr [8];
   logic [2:0]  m_wp;
   logic [2:0]  m_rp;
   int          ack_cnt;

   int          n_cmp;
   int          n_fail;
   logic [31:0] got_pc   [8];
   logic [31:0] got_inst [8];
   int          got_cyc  [8];
   int          got_n;

   fetch_unit dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst_valid  (inst_valid),
      .o_inst        (inst),
      .o_inst_pc     (inst_pc),
      .i_inst_ready  (inst_ready)
`ifdef FETCH_STALL_CNT_EN
      ,
      .o_stall_cnt   (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: accepts when enabled, answers in order one cycle later at the earliest.
   assign imem_ack    = imem_req & ack_en;
   assign imem_rvalid = resp_en && (m_wp != m_rp);
   assign imem_rdata  = pend_addr[m_rp] ^ INST_KEY;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_wp    <= '0;
         m_rp    <= '0;
         ack_cnt <= 0;
      end else begin
         if (imem_ack) begin
            pend_addr[m_wp] <= imem_addr;
            m_wp            <= m_wp + 3'd1;
            ack_cnt         <= ack_cnt + 1;
         end
         if (imem_rvalid) begin
            m_rp <= m_rp + 3'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      ack_en      = 1'b0;
      resp_en     = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Records deliveries (ready assumed high) until n are seen or the budget runs out.
   task automatic collect(input int n, input int max_cycles);
      got_n = 0;
      for (int cyc = 0; cyc < max_cycles; cyc++) begin
         if (inst_valid) begin
            got_pc[got_n]   = inst_pc;
            got_inst[got_n] = inst;
            got_cyc[got_n]  = cyc;
            $display("deliver pc=%h inst=%h cycle=%0d", inst_pc, inst, cyc);
            got_n++;
         end
         if (got_n == n) break;
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ack_en = 1'b0; resp_en = 1'b0; inst_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b expected 1", imem_req); end
      n_cmp++;
      if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL release_addr: got %h expected %h", imem_addr, 32'h0); end
`ifdef FETCH_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      do_reset();
      ack_en = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
      collect(3, 20);
      n_cmp++;
      if (got_n !== 3) begin n_fail++; $display("FAIL stream_count: got %0d expected 3", got_n); end
      for (int k = 0; k < got_n; k++) begin
         exp_pc = 32'h0 + 32'(4 * k);
         n_cmp++;
         if (got_pc[k] !== exp_pc) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", k, got_pc[k], exp_pc); end
         n_cmp++;
         if (got_inst[k] !== (exp_pc ^ INST_KEY)) begin n_fail++; $display("FAIL stream_inst%0d: got %h expected %h", k, got_inst[k], exp_pc ^ INST_KEY); end
      end
      n_cmp++;
      if (got_cyc[0] !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", got_cyc[0]); end
      n_cmp++;
      if (got_cyc[1] !== 3) begin n_fail++; $display("FAIL stream_second: got %0d expected 3", got_cyc[1]); end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      do_reset();
      ack_en = 1'b1; resp_en = 1'b1; inst_ready = 1'b0;
      repeat (10) step();
      n_cmp++;
      if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", inst_valid); end
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b expected 0", imem_req); end
      n_cmp++;
      if (ack_cnt !== 2) begin n_fail++; $display("FAIL stall_acks: got %0d expected 2", ack_cnt); end
      n_cmp++;
      if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head: got %h expected %h", inst_pc, 32'h0); end
      inst_ready = 1'b1;
      collect(4, 30);
      n_cmp++;
      if (got_n !== 4) begin n_fail++; $display("FAIL resume_count: got %0d expected 4", got_n); end
      for (int k = 0; k < got_n; k++) begin
         exp_pc = 32'(4 * k);
         n_cmp++;
         if (got_pc[k] !== exp_pc) begin n_fail++; $display("FAIL resume_pc%0d: got %h expected %h", k, got_pc[k], exp_pc); end
      end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      ack_en = 1'b1; resp_en = 1'b0; inst_ready = 1'b1;
      step();
      step();
      n_cmp++;
      if (ack_cnt !== 2) begin n_fail++; $display("FAIL drain_pending: got %0d expected 2", ack_cnt); end
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_full_req: got %b expected 0", imem_req); end
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0; resp_en = 1'b1;
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req0: got %b expected 0", imem_req); end
      n_cmp++;
      if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL drain_addr: got %h expected %h", imem_addr, 32'h100); end
      step();
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req1: got %b expected 0", imem_req); end
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", inst_valid); end
      collect(1, 20);
      n_cmp++;
      if (got_n !== 1) begin n_fail++; $display("FAIL drain_count: got %0d expected 1", got_n); end
      n_cmp++;
      if (got_pc[0] !== 32'h100) begin n_fail++; $display("FAIL drain_pc: got %h expected %h", got_pc[0], 32'h100); end
      n_cmp++;
      if (got_inst[0] !== (32'h100 ^ INST_KEY)) begin n_fail++; $display("FAIL drain_inst: got %h expected %h", got_inst[0], 32'h100 ^ INST_KEY); end
   endtask

   task automatic test_redirect_align();
      do_reset();
      ack_en = 1'b1; resp_en = 1'b1; inst_ready = 1'b0;
      repeat (10) step();
      n_cmp++;
      if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL align_full: got %b expected 1", inst_valid); end
      redirect = 1'b1; redirect_pc = 32'h0000_0203;
      step();
      redirect = 1'b0;
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL align_flush: got %b expected 0", inst_valid); end
      n_cmp++;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL align_req: got %b expected 1", imem_req); end
      n_cmp++;
      if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL align_addr: got %h expected %h", imem_addr, 32'h200); end
      inst_ready = 1'b1;
      collect(2, 20);
      n_cmp++;
      if (got_n !== 2) begin n_fail++; $display("FAIL align_count: got %0d expected 2", got_n); end
      n_cmp++;
      if (got_pc[0] !== 32'h200) begin n_fail++; $display("FAIL align_pc0: got %h expected %h", got_pc[0], 32'h200); end
      n_cmp++;
      if (got_pc[1] !== 32'h204) begin n_fail++; $display("FAIL align_pc1: got %h expected %h", got_pc[1], 32'h204); end
   endtask

   task automatic test_redirect_coincide();
      do_reset();
      ack_en = 1'b1; resp_en = 1'b1; inst_ready = 1'b1;
      step();
      n_cmp++;
      if ({imem_req, imem_rvalid} !== 2'b11) begin n_fail++; $display("FAIL coin_setup: got %b expected 11", {imem_req, imem_rvalid}); end
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      step();
      redirect = 1'b0;
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL coin_drain_req: got %b expected 0", imem_req); end
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL coin_valid: got %b expected 0", inst_valid); end
      step();
      n_cmp++;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL coin_resume_req: got %b expected 1", imem_req); end
      n_cmp++;
      if (imem_addr !== 32'h300) begin n_fail++; $display("FAIL coin_addr: got %h expected %h", imem_addr, 32'h300); end
      collect(1, 20);
      n_cmp++;
      if (got_pc[0] !== 32'h300) begin n_fail++; $display("FAIL coin_pc: got %h expected %h", got_pc[0], 32'h300); end
      n_cmp++;
      if (got_inst[0] !== (32'h300 ^ INST_KEY)) begin n_fail++; $display("FAIL coin_inst: got %h expected %h", got_inst[0], 32'h300 ^ INST_KEY); end
   endtask

`ifdef FETCH_STALL_CNT_EN
   task automatic test_stall_cnt();
      do_reset();
      ack_en = 1'b0; resp_en = 1'b0; inst_ready = 1'b1;
      repeat (5) step();
      n_cmp++;
      if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt5: got %0d expected 5", stall_cnt); end
      inst_ready = 1'b0;
      step();
      n_cmp++;
      if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt_hold: got %0d expected 5", stall_cnt); end
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_redirect_align();
      test_redirect_coincide();
`ifdef FETCH_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
